// File: rtl/wtr_pkg.sv
// Shared definitions for the write-to-register burst sequencer: FSM encoding,
// default register count and the named register-file indices.
package wtr_pkg;

  localparam int WTR_NUM_REGS = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wtr_state_t;

  localparam logic [4:0] PC   = 5'd1;
  localparam logic [4:0] IR   = 5'd2;
  localparam logic [4:0] AR   = 5'd3;
  localparam logic [4:0] DR   = 5'd4;
  localparam logic [4:0] TR   = 5'd5;
  localparam logic [4:0] N    = 5'd6;
  localparam logic [4:0] M    = 5'd7;
  localparam logic [4:0] P    = 5'd8;
  localparam logic [4:0] ROW  = 5'd9;
  localparam logic [4:0] COL  = 5'd10;
  localparam logic [4:0] CURR = 5'd11;
  localparam logic [4:0] SUM  = 5'd12;
  localparam logic [4:0] AVAL = 5'd13;
  localparam logic [4:0] STA  = 5'd14;
  localparam logic [4:0] STB  = 5'd15;
  localparam logic [4:0] STC  = 5'd16;
  localparam logic [4:0] A    = 5'd17;
  localparam logic [4:0] B    = 5'd18;
  localparam logic [4:0] AC   = 5'd19;

endpackage

// File: rtl/wtr_onehot_dec.sv
// Register index to one-hot write-enable decoder. Index i drives bit i-1;
// index 0, out-of-range indices and en_i=0 all give an all-zero vector.
module wtr_onehot_dec #(
  parameter int NUM_REGS = 19,
  parameter int SEL_W    = 5
) (
  input  logic                en_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign onehot_o[g] = en_i && (sel_i == SEL_W'(g + 1));
  end

endmodule

// File: rtl/wtr_burst_sequencer.sv
// Burst write-enable sequencer: takes a start index and a count, then enables
// consecutive registers (wrapping NUM_REGS -> 1) one per cycle.
module wtr_burst_sequencer
  import wtr_pkg::*;
#(
  parameter int NUM_REGS = WTR_NUM_REGS,
  parameter int SEL_W    = 5,
  parameter int LEN_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                stall,
  input  logic                abort,
  output logic [NUM_REGS-1:0] wtr_onehot,
  output logic [SEL_W-1:0]    wtr_idx,
  output logic                done,
  output logic                err
);

  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1'b1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_REGS);
  localparam logic [LEN_W:0]   LEN_ONE = (LEN_W + 1)'(1'b1);

  wtr_state_t       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic             err_q, err_d;

  logic             sel_legal_s;
  logic [LEN_W:0]   len_eff_s;
  logic             write_en_s;

  assign sel_legal_s = (req_sel != '0) && (req_sel <= SEL_MAX);
  assign len_eff_s   = (req_len == '0) ? LEN_ONE : {1'b0, req_len};

  // Next-state logic; abort wins over stall and never produces done or err.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !abort) begin
          if (sel_legal_s) begin
            state_d = ST_WRITE;
            idx_d   = req_sel;
            rem_d   = len_eff_s;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          rem_d   = '0;
        end else if (!stall) begin
          rem_d = rem_q - LEN_ONE;
          idx_d = (idx_q == SEL_MAX) ? SEL_ONE : (idx_q + SEL_ONE);
          if (rem_q == LEN_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        rem_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        rem_d   = '0;
      end
    endcase
  end

  // State and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Only the write strobe sees stall directly; everything else is state-decoded.
  assign write_en_s = (state_q == ST_WRITE) && !stall;
  assign req_ready  = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign wtr_idx    = write_en_s ? idx_q : '0;

  wtr_onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_dec (
    .en_i     (write_en_s),
    .sel_i    (idx_q),
    .onehot_o (wtr_onehot)
  );

endmodule

// File: tb/tb_wtr_burst_sequencer.sv
// Scoreboard bench for wtr_burst_sequencer: a queue-of-indices reference model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_wtr_burst_sequencer;

  localparam int NR = 19;

  typedef struct packed {
    logic        ready;
    logic [18:0] oh;
    logic [4:0]  idx;
    logic        done;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_sel = 5'd0;
  logic [4:0]  req_len = 5'd0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic [18:0] wtr_onehot;
  logic [4:0]  wtr_idx;
  logic        done;
  logic        err;

  obs_t exp_q[$];
  int   pend[$];
  bit   done_p;
  bit   err_p;
  int   n_cmp;
  int   n_fail;

  wtr_burst_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_len    (req_len),
    .stall      (stall),
    .abort      (abort),
    .wtr_onehot (wtr_onehot),
    .wtr_idx    (wtr_idx),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name, input obs_t e);
    obs_t a;
    a = {req_ready, wtr_onehot, wtr_idx, done, err};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: actual rdy=%b oh=%05h idx=%0d done=%b err=%b, expected rdy=%b oh=%05h idx=%0d done=%b err=%b",
               name, $time, a.ready, a.oh, a.idx, a.done, a.err,
               e.ready, e.oh, e.idx, e.done, e.err);
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic cyc(input bit v, input int sel, input int len, input bit st, input bit ab);
    obs_t        e;
    bit          busy;
    bit          idle;
    bit          legal;
    bit          nerr;
    int          w;
    int          n;
    logic [18:0] one;
    @(posedge clk);
    #1;
    req_valid = v;
    req_sel   = sel[4:0];
    req_len   = len[4:0];
    stall     = st;
    abort     = ab;
    busy  = pend.size() > 0;
    idle  = !busy && !done_p;
    e       = '0;
    e.ready = idle;
    e.done  = done_p;
    e.err   = err_p;
    if (busy && !st) begin
      w     = pend[0];
      one   = 19'd1;
      e.oh  = one << (w - 1);
      e.idx = w[4:0];
    end
    exp_q.push_back(e);
    legal = (sel >= 1) && (sel <= NR);
    nerr  = idle && v && !ab && !legal;
    if (done_p) begin
      done_p = 1'b0;
    end else if (busy) begin
      if (ab) begin
        pend.delete();
      end else if (!st) begin
        void'(pend.pop_front());
        if (pend.size() == 0) done_p = 1'b1;
      end
    end else if (v && !ab && legal) begin
      n = (len == 0) ? 1 : len;
      for (int k = 0; k < n; k++) pend.push_back(((sel - 1 + k) % NR) + 1);
    end
    err_p = nerr;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic reset_mid();
    obs_t r;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    r       = '0;
    r.ready = 1'b1;
    check_out("async_reset", r);
    pend.delete();
    done_p = 1'b0;
    err_p  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("cycle", e);
      end
    end
  end

  initial begin : stimulus
    obs_t r;
    n_cmp  = 0;
    n_fail = 0;
    #1;
    r       = '0;
    r.ready = 1'b1;
    check_out("reset_state", r);
    #11 rst_n = 1'b1;

    idle_cycles(2);
    cyc(1'b1, 1, 1, 1'b0, 1'b0);
    idle_cycles(3);
    cyc(1'b1, 18, 4, 1'b0, 1'b0);
    idle_cycles(6);
    cyc(1'b1, 5, 3, 1'b0, 1'b0);
    idle_cycles(1);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    idle_cycles(5);
    cyc(1'b1, 0, 2, 1'b0, 1'b0);
    idle_cycles(1);
    cyc(1'b1, 20, 2, 1'b0, 1'b0);
    idle_cycles(2);
    cyc(1'b1, 10, 6, 1'b0, 1'b0);
    idle_cycles(2);
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    idle_cycles(1);
    cyc(1'b1, 3, 2, 1'b0, 1'b0);
    idle_cycles(4);
    cyc(1'b1, 4, 2, 1'b0, 1'b1);
    cyc(1'b1, 25, 2, 1'b0, 1'b1);
    idle_cycles(2);
    cyc(1'b1, 2, 8, 1'b0, 1'b0);
    idle_cycles(2);
    reset_mid();
    cyc(1'b1, 19, 0, 1'b0, 1'b0);
    idle_cycles(3);
    cyc(1'b1, 7, 25, 1'b0, 1'b0);
    idle_cycles(28);

    for (int i = 0; i < 3000; i++) begin
      int sel;
      int len;
      bit v;
      bit st;
      bit ab;
      v   = $urandom_range(0, 1) == 1;
      sel = ($urandom_range(0, 99) < 85) ? $urandom_range(1, NR) : $urandom_range(0, 31);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      st  = $urandom_range(0, 4) == 0;
      ab  = $urandom_range(0, 24) == 0;
      if ($urandom_range(0, 399) == 0) reset_mid();
      else cyc(v, sel, len, st, ab);
    end

    for (int i = 0; i < 200 && (pend.size() > 0 || done_p || err_p); i++) idle_cycles(1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d predictions still queued, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
